regf_loader: RTL and testbench
==============================

REGF_LOADER -- requirements
Module: regf_loader

Interface
REQ-001 Parameter DW, default 8, data width; matches the register file write-data width.
REQ-002 Parameter AW, default 2, address width; the register file has 2**AW entries.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  one-cycle request to begin a burst; honoured only in IDLE.
REQ-006 base_addr  input  AW  first register address of the burst; sampled with start.
REQ-007 len  input  AW  burst length minus one (0..3 gives 1..4 bytes); sampled with start.
REQ-008 abort  input  1  cancels an active burst.
REQ-009 in_data  input  DW  byte offered by the upstream source.
REQ-010 in_valid  input  1  in_data is valid.
REQ-011 in_ready  output  1  loader accepts in_data this cycle.
REQ-012 wr_data  output  DW  register file write data.
REQ-013 wr_addr  output  AW  register file write address.
REQ-014 wr_e  output  1  register file write enable, one cycle per accepted byte.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at burst completion.
REQ-017 csum  output  DW  mod-2**DW sum of the bytes written in the last completed burst.

Function
REQ-018 FSM states are IDLE, LOAD and DONE.
- IDLE->LOAD on start.
- LOAD->DONE on acceptance of the final byte.
- LOAD->IDLE on abort.
- DONE->IDLE unconditionally after one cycle.
REQ-019 On start in IDLE: addr register <- base_addr, remaining <- len, running sum <- 0.
REQ-020 in_ready is 1 only in LOAD with abort low.
- Combinational from state and abort.
- Independent of in_valid.
REQ-021 A byte is accepted when in_valid and in_ready are both 1 at a clock edge.
REQ-022 Each accepted byte appears on the outputs on the next cycle.
- wr_e = 1, wr_data = the byte, wr_addr = current addr register.
- Latency exactly 1 cycle; all three outputs are registered.
REQ-023 wr_e is 0 in every cycle that does not follow an acceptance.
- wr_data and wr_addr hold their last values while wr_e is 0.
REQ-024 After each acceptance, addr increments modulo 2**AW; base 3 then wraps to 0.
REQ-025 After each acceptance, the running sum is updated to sum + byte (mod 2**DW).
REQ-026 When remaining = 0, the acceptance is the final byte.
- The FSM enters DONE.
- The write for that byte is issued in the DONE cycle.
REQ-027 In DONE: done = 1 and csum = the final running sum; csum holds that value until the next DONE.
REQ-028 start in LOAD or DONE is ignored; it is not queued.
REQ-029 abort in LOAD:
- A byte offered in the same cycle is not accepted (in_ready = 0).
- A wr_e already scheduled from the previous cycle's acceptance still completes.
- The FSM returns to IDLE, done is not pulsed and csum is unchanged.
REQ-030 abort in IDLE or DONE has no effect.
REQ-031 in_valid in IDLE or DONE is ignored: no acceptance, no write.

Reset
REQ-032 rst overrides all other inputs, including mid-burst.
REQ-033 On the first edge with rst = 1, the block enters this reset state:
- FSM in IDLE.
- wr_e = 0, wr_data = 0, wr_addr = 0.
- busy = 0, done = 0, csum = 0.
- addr = 0, remaining = 0, running sum = 0.
REQ-034 A write pending from the cycle before reset is dropped.

Structure
REQ-035 Shared package regf_pkg holds:
- The state enumeration (IDLE, LOAD, DONE).
- The default DW and AW constants.
REQ-036 No sub-modules; a single module is sufficient.

Verification
REQ-037 Full burst: start, base_addr = 0, len = 3, in_valid held high with bytes 1, 2, 3, 4.
- Required: wr_e on 4 consecutive cycles, addr 0, 1, 2, 3, data 1, 2, 3, 4.
- Required: done in the cycle of the 4th write, with csum = 10.
REQ-038 Wrap: base_addr = 3, len = 2, bytes 0x10, 0x20, 0x30.
- Required: writes at addr 3, 0, 1; csum = 0x60.
REQ-039 Backpressure gaps: in_valid low for 2 cycles between bytes.
- Required: no wr_e during the gaps; the address sequence is unchanged.
REQ-040 Abort: abort asserted while the 2nd byte is offered in a 4-byte burst.
- Required: exactly 1 write; no done; csum keeps its previous value; busy = 0 next cycle.
REQ-041 Reset mid-burst: rst after 2 bytes are accepted.
- Required: all outputs at reset values next cycle.
- Required: a new burst from base_addr = 1 then writes to 1 correctly.
REQ-042 Checksum overflow: bytes 0xFF and 0x02 with len = 1 -> csum = 0x01.
- Also in this bench: start during LOAD has no effect.

Source files
------------

// File: rtl/regf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regf_pkg
// Description : Shared types and default widths for the register-file loader.
// Revision    : 1.0 - initial release
// ============================================================================
package regf_pkg;

    localparam int DEFAULT_DW = 8;
    localparam int DEFAULT_AW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : regf_pkg
`default_nettype wire

// File: rtl/regf_loader.sv
`default_nettype none
// ============================================================================
// Module      : regf_loader
// Description : Streams a 1..4 byte burst into consecutive register-file
//               entries and reports a modulo checksum of each completed burst.
// Revision    : 1.0 - initial release
// ============================================================================
module regf_loader
    import regf_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len,
    input  logic          abort,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_e,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] csum
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          wr_e_q, wr_e_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] csum_q, csum_d;
    logic          accept;

    // Abort masks ready so a byte offered alongside abort is never consumed.
    assign in_ready = (state_q == LOAD) && !abort;
    assign accept   = in_ready && in_valid;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        sum_d     = sum_q;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        wr_e_d    = 1'b0;
        done_d    = 1'b0;
        csum_d    = csum_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    addr_d  = base_addr;
                    rem_d   = len;
                    sum_d   = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    wr_e_d    = 1'b1;
                    wr_data_d = in_data;
                    wr_addr_d = addr_q;
                    addr_d    = addr_q + AW'(1);
                    rem_d     = rem_q - AW'(1);
                    sum_d     = sum_q + in_data;
                    if (rem_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        csum_d  = sum_q + in_data;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            sum_q     <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            wr_e_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            csum_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            sum_q     <= sum_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            wr_e_q    <= wr_e_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            csum_q    <= csum_d;
        end
    end

    assign wr_data = wr_data_q;
    assign wr_addr = wr_addr_q;
    assign wr_e    = wr_e_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign csum    = csum_q;

endmodule : regf_loader
`default_nettype wire

// File: tb/tb_regf_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regf_loader
// Description : Self-checking bench for regf_loader: directed bursts plus
//               randomized bursts against a burst-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regf_loader;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len;
    logic          abort;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_e;
    logic          busy;
    logic          done;
    logic [DW-1:0] csum;

    int tests_run    = 0;
    int tests_failed = 0;

    regf_loader #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .wr_e      (wr_e),
        .busy      (busy),
        .done      (done),
        .csum      (csum)
    );

    always #5 clk = ~clk;

    // Observed write stream and done pulses, sampled mid-cycle.
    int            cyc = 0;
    logic [AW-1:0] act_addr[$];
    logic [DW-1:0] act_data[$];
    int            act_cyc[$];
    int            done_cnt;
    int            done_cyc;
    logic [DW-1:0] done_csum;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_e === 1'b1) begin
            act_addr.push_back(wr_addr);
            act_data.push_back(wr_data);
            act_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_csum = csum;
        end
    end

    logic [DW-1:0] burst_bytes[4];
    logic [DW-1:0] model_csum;
    logic          ready_at_abort;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        act_addr.delete();
        act_data.delete();
        act_cyc.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        done_csum = '0;
    endtask

    // Plays one burst; abort_idx >= 0 raises abort while that byte is offered.
    task automatic drive_burst(input logic [AW-1:0] base, input logic [AW-1:0] ln,
                               input int gap_max, input bit fixed_gap,
                               input int abort_idx, input bit poke_start);
        start     = 1'b1;
        base_addr = base;
        len       = ln;
        tick();
        start = 1'b0;
        for (int i = 0; i <= int'(ln); i++) begin
            int g;
            g = (i == 0) ? 0 : (fixed_gap ? gap_max : int'($urandom_range(gap_max, 0)));
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                if (poke_start) begin
                    start     = 1'b1;
                    base_addr = ~base;
                    len       = ~ln;
                end
                tick();
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = burst_bytes[i];
            if (i == abort_idx) begin
                abort = 1'b1;
                #1 ready_at_abort = in_ready;
                tick();
                abort    = 1'b0;
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        base_addr = '0; len = '0; in_data = '0;
        tick();
        tick();
        tests_run++; if (wr_e !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_e got=%b exp=0", wr_e); end
        tests_run++; if (wr_data !== '0) begin tests_failed++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
        tests_run++; if (wr_addr !== '0) begin tests_failed++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
        tests_run++; if (csum !== '0) begin tests_failed++; $display("FAIL reset_csum got=%h exp=00", csum); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        model_csum = '0;
        tick();
    endtask

    task automatic test_full_burst;
        clear_mon();
        burst_bytes = '{8'd1, 8'd2, 8'd3, 8'd4};
        drive_burst(2'd0, 2'd3, 0, 1'b1, -1, 1'b0);
        model_csum = 8'd10;
        tests_run++; if (act_addr.size() != 4) begin tests_failed++; $display("FAIL full_count got=%0d exp=4", act_addr.size()); end
        for (int i = 0; i < 4 && i < act_addr.size(); i++) begin
            tests_run++; if (act_addr[i] !== AW'(i)) begin tests_failed++; $display("FAIL full_addr[%0d] got=%0d exp=%0d", i, act_addr[i], i); end
            tests_run++; if (act_data[i] !== DW'(i + 1)) begin tests_failed++; $display("FAIL full_data[%0d] got=%0d exp=%0d", i, act_data[i], i + 1); end
            tests_run++; if (act_cyc[i] != act_cyc[0] + i) begin tests_failed++; $display("FAIL full_consecutive[%0d] got=%0d exp=%0d", i, act_cyc[i], act_cyc[0] + i); end
        end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL full_done_cnt got=%0d exp=1", done_cnt); end
        if (act_cyc.size() == 4) begin
            tests_run++; if (done_cyc != act_cyc[3]) begin tests_failed++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_cyc, act_cyc[3]); end
        end
        tests_run++; if (done_csum !== 8'd10) begin tests_failed++; $display("FAIL full_done_csum got=%0d exp=10", done_csum); end
        tick();
        tests_run++; if (csum !== 8'd10) begin tests_failed++; $display("FAIL full_csum_hold got=%0d exp=10", csum); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL full_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] exp_addr[3];
        exp_addr = '{2'd3, 2'd0, 2'd1};
        clear_mon();
        burst_bytes = '{8'h10, 8'h20, 8'h30, 8'h00};
        drive_burst(2'd3, 2'd2, 0, 1'b1, -1, 1'b0);
        model_csum = 8'h60;
        tests_run++; if (act_addr.size() != 3) begin tests_failed++; $display("FAIL wrap_count got=%0d exp=3", act_addr.size()); end
        for (int i = 0; i < 3 && i < act_addr.size(); i++) begin
            tests_run++; if (act_addr[i] !== exp_addr[i]) begin tests_failed++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, act_addr[i], exp_addr[i]); end
        end
        tests_run++; if (csum !== 8'h60) begin tests_failed++; $display("FAIL wrap_csum got=%h exp=60", csum); end
    endtask

    task automatic test_gaps;
        int s;
        clear_mon();
        s = 0;
        for (int i = 0; i < 4; i++) begin
            burst_bytes[i] = DW'($urandom);
            s += int'(burst_bytes[i]);
        end
        drive_burst(2'd1, 2'd3, 2, 1'b1, -1, 1'b0);
        model_csum = DW'(s);
        tests_run++; if (act_addr.size() != 4) begin tests_failed++; $display("FAIL gaps_count got=%0d exp=4", act_addr.size()); end
        for (int i = 0; i < 4 && i < act_addr.size(); i++) begin
            tests_run++; if (act_addr[i] !== AW'((1 + i) % NREG)) begin tests_failed++; $display("FAIL gaps_addr[%0d] got=%0d exp=%0d", i, act_addr[i], (1 + i) % NREG); end
            tests_run++; if (act_data[i] !== burst_bytes[i]) begin tests_failed++; $display("FAIL gaps_data[%0d] got=%h exp=%h", i, act_data[i], burst_bytes[i]); end
            if (i > 0) begin
                tests_run++; if (act_cyc[i] - act_cyc[i-1] != 3) begin tests_failed++; $display("FAIL gaps_spacing[%0d] got=%0d exp=3", i, act_cyc[i] - act_cyc[i-1]); end
            end
        end
        tests_run++; if (csum !== model_csum) begin tests_failed++; $display("FAIL gaps_csum got=%h exp=%h", csum, model_csum); end
    endtask

    task automatic test_abort;
        logic [DW-1:0] prev;
        prev = model_csum;
        clear_mon();
        burst_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        drive_burst(2'd2, 2'd3, 0, 1'b1, 1, 1'b0);
        tests_run++; if (ready_at_abort !== 1'b0) begin tests_failed++; $display("FAIL abort_in_ready got=%b exp=0", ready_at_abort); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got=%b exp=0", busy); end
        repeat (3) tick();
        tests_run++; if (act_addr.size() != 1) begin tests_failed++; $display("FAIL abort_writes got=%0d exp=1", act_addr.size()); end
        if (act_addr.size() >= 1) begin
            tests_run++; if (act_addr[0] !== 2'd2 || act_data[0] !== 8'hA1) begin tests_failed++; $display("FAIL abort_first_write got=%0d/%h exp=2/a1", act_addr[0], act_data[0]); end
        end
        tests_run++; if (done_cnt != 0) begin tests_failed++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
        tests_run++; if (csum !== prev) begin tests_failed++; $display("FAIL abort_csum got=%h exp=%h", csum, prev); end
    endtask

    task automatic test_reset_mid;
        clear_mon();
        start = 1'b1; base_addr = 2'd2; len = 2'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; rst = 1'b1; tick();
        in_valid = 1'b0;
        tests_run++; if (wr_e !== 1'b0) begin tests_failed++; $display("FAIL rstmid_wr_e got=%b exp=0", wr_e); end
        tests_run++; if (wr_data !== '0 || wr_addr !== '0) begin tests_failed++; $display("FAIL rstmid_wr_bus got=%h/%0d exp=00/0", wr_data, wr_addr); end
        tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy_done got=%b/%b exp=0/0", busy, done); end
        tests_run++; if (csum !== '0) begin tests_failed++; $display("FAIL rstmid_csum got=%h exp=00", csum); end
        tests_run++; if (act_addr.size() != 2) begin tests_failed++; $display("FAIL rstmid_writes got=%0d exp=2", act_addr.size()); end
        rst = 1'b0;
        model_csum = '0;
        tick();
        clear_mon();
        burst_bytes[0] = 8'h5A;
        drive_burst(2'd1, 2'd0, 0, 1'b1, -1, 1'b0);
        model_csum = 8'h5A;
        tests_run++; if (act_addr.size() != 1) begin tests_failed++; $display("FAIL rstmid_new_count got=%0d exp=1", act_addr.size()); end
        if (act_addr.size() >= 1) begin
            tests_run++; if (act_addr[0] !== 2'd1 || act_data[0] !== 8'h5A) begin tests_failed++; $display("FAIL rstmid_new_write got=%0d/%h exp=1/5a", act_addr[0], act_data[0]); end
        end
        tests_run++; if (csum !== 8'h5A) begin tests_failed++; $display("FAIL rstmid_new_csum got=%h exp=5a", csum); end
    endtask

    task automatic test_overflow_start;
        clear_mon();
        burst_bytes = '{8'hFF, 8'h02, 8'h00, 8'h00};
        drive_burst(2'd2, 2'd1, 1, 1'b1, -1, 1'b1);
        model_csum = 8'h01;
        tests_run++; if (act_addr.size() != 2) begin tests_failed++; $display("FAIL ovf_count got=%0d exp=2", act_addr.size()); end
        if (act_addr.size() == 2) begin
            tests_run++; if (act_addr[0] !== 2'd2 || act_addr[1] !== 2'd3) begin tests_failed++; $display("FAIL ovf_addr got=%0d,%0d exp=2,3", act_addr[0], act_addr[1]); end
        end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL ovf_done_cnt got=%0d exp=1", done_cnt); end
        tests_run++; if (csum !== 8'h01) begin tests_failed++; $display("FAIL ovf_csum got=%h exp=01", csum); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 30; it++) begin
            logic [AW-1:0] b, l;
            int ab, n, s;
            clear_mon();
            repeat ($urandom_range(3, 0)) begin
                in_valid = 1'($urandom);
                abort    = 1'($urandom);
                in_data  = DW'($urandom);
                tick();
            end
            in_valid = 1'b0;
            abort    = 1'b0;
            tests_run++; if (act_addr.size() != 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rand_idle[%0d] writes=%0d busy=%b exp=0/0", it, act_addr.size(), busy); end
            clear_mon();
            b  = AW'($urandom);
            l  = AW'($urandom);
            ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(int'(l), 0)) : -1;
            n  = (ab >= 0) ? ab : int'(l) + 1;
            s  = 0;
            for (int i = 0; i < 4; i++) burst_bytes[i] = DW'($urandom);
            for (int i = 0; i < n; i++) s += int'(burst_bytes[i]);
            drive_burst(b, l, 3, 1'b0, ab, 1'b0);
            tick();
            if (ab < 0) model_csum = DW'(s % (1 << DW));
            tests_run++; if (act_addr.size() != n) begin tests_failed++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", it, act_addr.size(), n); end
            for (int i = 0; i < n && i < act_addr.size(); i++) begin
                tests_run++;
                if (act_addr[i] !== AW'((int'(b) + i) % NREG) || act_data[i] !== burst_bytes[i]) begin
                    tests_failed++;
                    $display("FAIL rand_write[%0d][%0d] got=%0d/%h exp=%0d/%h", it, i, act_addr[i], act_data[i], (int'(b) + i) % NREG, burst_bytes[i]);
                end
            end
            tests_run++; if (done_cnt != ((ab < 0) ? 1 : 0)) begin tests_failed++; $display("FAIL rand_done_cnt[%0d] got=%0d exp=%0d", it, done_cnt, (ab < 0) ? 1 : 0); end
            if (ab < 0 && act_cyc.size() == n) begin
                tests_run++; if (done_cyc != act_cyc[n-1]) begin tests_failed++; $display("FAIL rand_done_cycle[%0d] got=%0d exp=%0d", it, done_cyc, act_cyc[n-1]); end
            end
            tests_run++; if (csum !== model_csum) begin tests_failed++; $display("FAIL rand_csum[%0d] got=%h exp=%h", it, csum, model_csum); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_burst();
        test_wrap();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_overflow_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_regf_loader
`default_nettype wire
